// File: rtl/leaf_stream_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ kernel output streams into one leaf_interface input.
// Optional per-requester beat counters are enabled with `define LEAF_ARB_STATS_EN.
module leaf_stream_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_LEN    = 16,
  parameter int REQ_BITS     = 2
) (
  input  logic                            clk,
  input  logic                            ap_rst_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         out_data,
  output logic                            out_vld,
  input  logic                            out_ack,
  output logic [REQ_BITS-1:0]             grant_idx,
  output logic                            busy
`ifdef LEAF_ARB_STATS_EN
  ,
  input  logic [REQ_BITS-1:0]             stat_sel,
  output logic [31:0]                     stat_cnt
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    load;
  logic                    xfer;
  logic                    granted_vld;
  logic                    pick_found;
  logic [REQ_BITS-1:0]     pick_idx;
  logic [PAYLOAD_BITS-1:0] sel_data;

  assign load = !out_vld || out_ack;
  assign xfer = |(req_vld & req_ack);

  always_comb begin
    req_ack     = '0;
    sel_data    = '0;
    granted_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == REQ_BITS'(i)) begin
        sel_data    = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        granted_vld = req_vld[i];
        req_ack[i]  = (state == GRANT) && load;
      end
    end
  end

  // Walk downward so the nearest requester after grant_idx is the last (winning) assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_idx;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_vld[REQ_BITS'((int'(grant_idx) + k) % NUM_REQ)]) begin
        pick_found = 1'b1;
        pick_idx   = REQ_BITS'((int'(grant_idx) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      out_vld   <= 1'b0;
      out_data  <= '0;
      grant_idx <= REQ_BITS'(NUM_REQ - 1);
      beat_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      if (xfer) begin
        out_data <= sel_data;
        out_vld  <= 1'b1;
      end else if (out_ack) begin
        out_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            state     <= GRANT;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          // A requester that goes quiet gives up the grant immediately.
          if (!granted_vld || (xfer && beat_cnt == LAST_BEAT)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LEAF_ARB_STATS_EN
  logic [31:0] stat_mem [NUM_REQ];

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_mem[i] <= '0;
      end
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_vld[i] && req_ack[i]) begin
          stat_mem[i] <= stat_mem[i] + 32'd1;
        end
      end
      stat_cnt <= stat_mem[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Directed self-checking bench for leaf_stream_arbiter; stat counter checks need LEAF_ARB_STATS_EN.
module tb_leaf_stream_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int PAYLOAD_BITS = 32;
  localparam int BURST_LEN    = 16;
  localparam int REQ_BITS     = 2;
  localparam int HIST         = 512;

  logic                            clk = 1'b0;
  logic                            ap_rst_n;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]              req_vld;
  logic [NUM_REQ-1:0]              req_ack;
  logic [PAYLOAD_BITS-1:0]         out_data;
  logic                            out_vld;
  logic                            out_ack;
  logic [REQ_BITS-1:0]             grant_idx;
  logic                            busy;
`ifdef LEAF_ARB_STATS_EN
  logic [REQ_BITS-1:0]             stat_sel;
  logic [31:0]                     stat_cnt;
`endif

  leaf_stream_arbiter #(
    .NUM_REQ(NUM_REQ), .PAYLOAD_BITS(PAYLOAD_BITS), .BURST_LEN(BURST_LEN), .REQ_BITS(REQ_BITS)
  ) dut (
    .clk(clk), .ap_rst_n(ap_rst_n), .req_data(req_data), .req_vld(req_vld), .req_ack(req_ack),
    .out_data(out_data), .out_vld(out_vld), .out_ack(out_ack), .grant_idx(grant_idx), .busy(busy)
`ifdef LEAF_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          sent  [NUM_REQ];
  int          limit [NUM_REQ];
  logic [31:0] base  [NUM_REQ];
  int          cyc;
  int          ack_lo;
  int          ack_hi;

  logic [31:0] obs_data [$];
  int          obs_cyc  [$];
  logic [31:0]        data_hist  [HIST];
  logic               vld_hist   [HIST];
  logic               busy_hist  [HIST];
  logic [NUM_REQ-1:0] ack_hist   [HIST];
  logic [REQ_BITS-1:0] grant_hist [HIST];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Each source presents beat base+sent until it has delivered limit beats.
  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vld[i] = (sent[i] < limit[i]);
      req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS] = base[i] + 32'(sent[i]);
    end
    out_ack = !(cyc >= ack_lo && cyc <= ack_hi);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    req_vld  = '0;
    req_data = '0;
    out_ack  = 1'b1;
    repeat (2) @(posedge clk);
    #1 ap_rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int l0, input int l1, input int l2, input int l3,
                               input int lo, input int hi, input bit tag_src);
    limit[0] = l0; limit[1] = l1; limit[2] = l2; limit[3] = l3;
    for (int i = 0; i < NUM_REQ; i++) begin
      sent[i] = 0;
      base[i] = tag_src ? 32'(i) << 8 : 32'd0;
    end
    ack_lo = lo;
    ack_hi = hi;
    cyc    = 0;
    obs_data.delete();
    obs_cyc.delete();
    drive_inputs();
  endtask

  // Sample mid-cycle, then update sources just after the edge that consumed their beats.
  task automatic step();
    logic [NUM_REQ-1:0] pend;
    @(negedge clk);
    data_hist[cyc]  = out_data;
    vld_hist[cyc]   = out_vld;
    busy_hist[cyc]  = busy;
    ack_hist[cyc]   = req_ack;
    grant_hist[cyc] = grant_idx;
    if (out_vld && out_ack) begin
      obs_data.push_back(out_data);
      obs_cyc.push_back(cyc);
    end
    pend = req_vld & req_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[i]) sent[i]++;
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until(input int want, input int max_cyc);
    while (obs_data.size() < want && cyc < max_cyc) step();
    checkOutput("beat_count", 32'(obs_data.size()), 32'(want));
  endtask

  initial begin
    ap_rst_n = 1'b0;
    req_vld  = '0;
    req_data = '0;
    out_ack  = 1'b1;
    ack_lo   = -1;
    ack_hi   = -2;
    cyc      = 0;
`ifdef LEAF_ARB_STATS_EN
    stat_sel = '0;
`endif

    // Reset values
    do_reset();
    #2;
    checkOutput("rst_out_vld", 32'(out_vld), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_grant_idx", 32'(grant_idx), 32'd3);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Single requester 2, beats 0..39, re-arbitration bubble every 16 beats
    applyStimulus(0, 0, 40, 0, -1, -2, 1'b0);
    run_until(40, 200);
    for (int k = 0; k < obs_data.size(); k++) begin
      checkOutput("t1_data", obs_data[k], 32'(k));
      checkOutput("t1_cycle", 32'(obs_cyc[k]), 32'(2 + k + int'(k >= 16) + int'(k >= 32)));
    end

    // Four requesters x 20 beats: bursts 16,16,16,16 then 4,4,4,4
    do_reset();
    applyStimulus(20, 20, 20, 20, -1, -2, 1'b1);
    run_until(80, 400);
    for (int j = 0; j < obs_data.size(); j++) begin
      int src;
      int idx;
      if (j < 64) begin
        src = j / 16;
        idx = j % 16;
      end else begin
        src = (j - 64) / 4;
        idx = 16 + (j - 64) % 4;
      end
      checkOutput("t2_data", obs_data[j], 32'((src << 8) | idx));
    end

`ifdef LEAF_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_sel = REQ_BITS'(i);
      @(posedge clk);
      @(negedge clk);
      checkOutput("stat_cnt", stat_cnt, 32'd20);
      @(posedge clk);
      #1;
    end
`endif

    // Requester 1 quits after 3 beats, requester 3 takes over
    do_reset();
    applyStimulus(0, 3, 0, 5, -1, -2, 1'b1);
    run_until(8, 100);
    for (int j = 0; j < obs_data.size(); j++) begin
      if (j < 3) begin
        checkOutput("t3_data", obs_data[j], 32'((1 << 8) | j));
        checkOutput("t3_cycle", 32'(obs_cyc[j]), 32'(2 + j));
      end else begin
        checkOutput("t3_data", obs_data[j], 32'((3 << 8) | (j - 3)));
        checkOutput("t3_cycle", 32'(obs_cyc[j]), 32'(7 + j - 3));
      end
    end
    checkOutput("t3_release_busy", 32'(busy_hist[5]), 32'd0);
    checkOutput("t3_regrant_idx", 32'(grant_hist[6]), 32'd3);
    checkOutput("t3_regrant_busy", 32'(busy_hist[6]), 32'd1);

    // out_ack held low for cycles 5..14 while beat 3 sits in the output register
    do_reset();
    applyStimulus(30, 0, 0, 0, 5, 14, 1'b1);
    run_until(30, 200);
    for (int s = 5; s <= 14; s++) begin
      checkOutput("t4_stall_data", data_hist[s], 32'd3);
      checkOutput("t4_stall_vld", 32'(vld_hist[s]), 32'd1);
      checkOutput("t4_stall_ack", 32'(ack_hist[s]), 32'd0);
      checkOutput("t4_stall_busy", 32'(busy_hist[s]), 32'd1);
    end
    for (int k = 0; k < obs_data.size(); k++) begin
      int ec;
      ec = (k < 3) ? 2 + k : (k < 16) ? 12 + k : 13 + k;
      checkOutput("t4_data", obs_data[k], 32'(k));
      checkOutput("t4_cycle", 32'(obs_cyc[k]), 32'(ec));
    end

    // Asynchronous reset mid-burst, then requester 0 must win again
    do_reset();
    applyStimulus(20, 20, 0, 0, -1, -2, 1'b1);
    for (int s = 0; s < 6; s++) step();
    #2;
    checkOutput("t5_pre_vld", 32'(out_vld), 32'd1);
    checkOutput("t5_pre_grant", 32'(grant_idx), 32'd0);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_vld", 32'(out_vld), 32'd0);
    checkOutput("t5_rst_ack", 32'(req_ack), 32'd0);
    checkOutput("t5_rst_grant", 32'(grant_idx), 32'd3);
    @(posedge clk);
    #1 ap_rst_n = 1'b1;
    applyStimulus(20, 20, 0, 0, -1, -2, 1'b1);
    run_until(1, 50);
    if (obs_data.size() > 0) begin
      checkOutput("t5_first_data", obs_data[0], 32'd0);
      checkOutput("t5_first_cycle", 32'(obs_cyc[0]), 32'd2);
    end
    checkOutput("t5_first_grant", 32'(grant_hist[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
